// File: rtl/game_pkg.sv
// Shared game types and widths for the player charge meter and the throw controllers.
package game_pkg;

    localparam int FORCE_W = 10;
    localparam int WIND_W  = 7;

    localparam logic [WIND_W-1:0] WIND_CALM = 7'd50;
    localparam logic [WIND_W-1:0] WIND_MAX  = 7'd100;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CHARGE,
        LAUNCH,
        DONE
    } charge_state_t;

    // Fold the 101..127 tail of a 7-bit random value back into 74..100.
    function automatic logic [WIND_W-1:0] wind_from_lfsr(input logic [WIND_W-1:0] raw);
        logic [WIND_W-1:0] w;
        w = raw;
        if (w > WIND_MAX) begin
            w = w - WIND_W'(27);
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for a raw player button.
module btn_debounce #(
    parameter int DEB_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_db
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The count only advances while the synchronized level disagrees with the
    // accepted one; any agreeing cycle restarts it.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/throw_charge_ctl.sv
// Per-player charge meter: ping-pong force ramp while the button is held, then a
// latched force and per-turn wind handed to the throw controller.
module throw_charge_ctl
    import game_pkg::*;
#(
    parameter int          TICK_DIV   = 650000,
    parameter int          FORCE_STEP = 12,
    parameter int          FORCE_MIN  = 64,
    parameter int          FORCE_MAX  = 1000,
    parameter int          DEB_CYCLES = 65000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn,
    input  logic               turn_active,
    input  logic               throw_done,
    output logic [FORCE_W-1:0] throw_force,
    output logic [WIND_W-1:0]  wind_force,
    output logic               throw_enable,
    output logic               charging,
    output logic               turn_over
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [FORCE_W:0] STEP_X = (FORCE_W + 1)'(FORCE_STEP);
    localparam logic [FORCE_W:0] MIN_X  = (FORCE_W + 1)'(FORCE_MIN);
    localparam logic [FORCE_W:0] MAX_X  = (FORCE_W + 1)'(FORCE_MAX);

    logic btn_db;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .btn_db (btn_db)
    );

    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic               tick;
    logic [15:0]        lfsr_q, lfsr_d;
    charge_state_t      state_q, state_d;
    logic [FORCE_W-1:0] force_q, force_d;
    logic [WIND_W-1:0]  wind_q, wind_d;
    logic               dir_up_q, dir_up_d;
    logic               seen_rel_q, seen_rel_d;
    logic               enable_q, enable_d;
    logic               charging_q, charging_d;
    logic               turn_over_q, turn_over_d;
    logic [FORCE_W:0]   force_next;

    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        // One extra bit so the step can overshoot before the clamp.
        force_next = dir_up_q ? ({1'b0, force_q} + STEP_X) : ({1'b0, force_q} - STEP_X);
    end

    always_comb begin
        state_d    = state_q;
        force_d    = force_q;
        wind_d     = wind_q;
        dir_up_d   = dir_up_q;
        seen_rel_d = seen_rel_q;
        case (state_q)
            IDLE: begin
                if (turn_active) begin
                    wind_d     = wind_from_lfsr(lfsr_q[WIND_W-1:0]);
                    seen_rel_d = 1'b0;
                    state_d    = ARMED;
                end
            end
            ARMED: begin
                if (!turn_active) begin
                    force_d = '0;
                    wind_d  = WIND_CALM;
                    state_d = IDLE;
                end else if (!btn_db) begin
                    seen_rel_d = 1'b1;
                end else if (seen_rel_q) begin
                    force_d  = FORCE_W'(FORCE_MIN);
                    dir_up_d = 1'b1;
                    state_d  = CHARGE;
                end
            end
            CHARGE: begin
                // Release is checked before the tick so a coincident tick is dropped.
                if (!turn_active) begin
                    force_d = '0;
                    wind_d  = WIND_CALM;
                    state_d = IDLE;
                end else if (!btn_db) begin
                    state_d = LAUNCH;
                end else if (tick) begin
                    if (force_next >= MAX_X) begin
                        force_d  = FORCE_W'(FORCE_MAX);
                        dir_up_d = 1'b0;
                    end else if (force_next <= MIN_X) begin
                        force_d  = FORCE_W'(FORCE_MIN);
                        dir_up_d = 1'b1;
                    end else begin
                        force_d = force_next[FORCE_W-1:0];
                    end
                end
            end
            LAUNCH: begin
                if (throw_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                force_d = '0;
                wind_d  = WIND_CALM;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        enable_d    = (state_d == LAUNCH);
        charging_d  = (state_d == CHARGE);
        turn_over_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q  <= '0;
            lfsr_q      <= LFSR_SEED;
            state_q     <= IDLE;
            force_q     <= '0;
            wind_q      <= WIND_CALM;
            dir_up_q    <= 1'b1;
            seen_rel_q  <= 1'b0;
            enable_q    <= 1'b0;
            charging_q  <= 1'b0;
            turn_over_q <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            lfsr_q      <= lfsr_d;
            state_q     <= state_d;
            force_q     <= force_d;
            wind_q      <= wind_d;
            dir_up_q    <= dir_up_d;
            seen_rel_q  <= seen_rel_d;
            enable_q    <= enable_d;
            charging_q  <= charging_d;
            turn_over_q <= turn_over_d;
        end
    end

    assign throw_force  = force_q;
    assign wind_force   = wind_q;
    assign throw_enable = enable_q;
    assign charging     = charging_q;
    assign turn_over    = turn_over_q;

endmodule

// File: tb/tb_throw_charge_ctl.sv
// Scenario bench for throw_charge_ctl with shrunk tick and debounce constants.
module tb_throw_charge_ctl;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;
    localparam int STEP     = 12;
    localparam int FMIN     = 64;
    localparam int FMAX     = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       turn_active = 1'b0;
    logic       throw_done = 1'b0;
    logic [9:0] throw_force;
    logic [6:0] wind_force;
    logic       throw_enable;
    logic       charging;
    logic       turn_over;

    int          errors = 0;
    int          checks = 0;
    int          cyc;
    logic [15:0] m_lfsr;
    int          m_force;
    bit          m_up;

    throw_charge_ctl #(
        .TICK_DIV   (TICK_DIV),
        .FORCE_STEP (STEP),
        .FORCE_MIN  (FMIN),
        .FORCE_MAX  (FMAX),
        .DEB_CYCLES (DEB),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn          (btn),
        .turn_active  (turn_active),
        .throw_done   (throw_done),
        .throw_force  (throw_force),
        .wind_force   (wind_force),
        .throw_enable (throw_enable),
        .charging     (charging),
        .turn_over    (turn_over)
    );

    always #5 clk = ~clk;

    // Edge count since reset release and the reference LFSR sequence.
    always @(posedge clk) begin
        if (rst) begin
            cyc    <= 0;
            m_lfsr <= 16'hACE1;
        end else begin
            cyc    <= cyc + 1;
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A tick is applied on edge number k whenever k is a multiple of TICK_DIV.
    function automatic bit is_tick_edge(input int k);
        return (k % TICK_DIV) == 0;
    endfunction

    task automatic model_tick();
        int n;
        n = m_up ? m_force + STEP : m_force - STEP;
        if (n >= FMAX) begin
            n = FMAX;
            m_up = 1'b0;
        end else if (n <= FMIN) begin
            n = FMIN;
            m_up = 1'b1;
        end
        m_force = n;
    endtask

    function automatic int wind_of(input logic [15:0] l);
        int w;
        w = int'(l[6:0]);
        if (w > 100) w = w - 27;
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        checks++;
        if (throw_force !== 10'd0 || wind_force !== 7'd50 || throw_enable !== 1'b0 ||
            charging !== 1'b0 || turn_over !== 1'b0)
            $display("FAIL reset_values got force=%0d wind=%0d en=%b chg=%b over=%b want 0/50/0/0/0",
                     throw_force, wind_force, throw_enable, charging, turn_over);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (throw_force !== 10'd0 || wind_force !== 7'd50 || throw_enable !== 1'b0 ||
                turn_over !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs cyc=%0d got force=%0d wind=%0d en=%b over=%b want 0/50/0/0",
                         cyc, throw_force, wind_force, throw_enable, turn_over);
            end
        end
    endtask

    task automatic test_ramp_abort();
        int ticks;
        int exp_wind;
        exp_wind    = wind_of(m_lfsr);
        turn_active = 1'b1;
        btn         = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (charging !== 1'b0 || throw_force !== 10'd0) begin
                errors++;
                $display("FAIL press_latency cyc=%0d got chg=%b force=%0d want 0/0",
                         cyc, charging, throw_force);
            end
        end
        step();
        m_force = FMIN;
        m_up    = 1'b1;
        checks++;
        if (charging !== 1'b1 || throw_force !== 10'd64) begin
            errors++;
            $display("FAIL charge_entry got chg=%b force=%0d want 1/64", charging, throw_force);
        end
        ticks = 0;
        while (ticks < 100) begin
            step();
            if (is_tick_edge(cyc)) begin
                model_tick();
                ticks++;
            end
            checks++;
            if (throw_force !== 10'(m_force) || charging !== 1'b1 || throw_enable !== 1'b0 ||
                wind_force !== 7'(exp_wind)) begin
                errors++;
                $display("FAIL ramp_value tick=%0d got force=%0d chg=%b en=%b wind=%0d want %0d/1/0/%0d",
                         ticks, throw_force, charging, throw_enable, wind_force, m_force, exp_wind);
            end
            checks++;
            if (throw_force < 10'd64 || throw_force > 10'd1000) begin
                errors++;
                $display("FAIL ramp_range got %0d want 64..1000", throw_force);
            end
            if (is_tick_edge(cyc) && ticks == 78) begin
                checks++;
                if (throw_force !== 10'd1000) begin
                    errors++;
                    $display("FAIL ramp_peak got %0d want 1000", throw_force);
                end
            end
            if (is_tick_edge(cyc) && ticks == 79) begin
                checks++;
                if (throw_force !== 10'd988) begin
                    errors++;
                    $display("FAIL ramp_turn got %0d want 988", throw_force);
                end
            end
        end
        turn_active = 1'b0;
        btn         = 1'b0;
        step();
        checks++;
        if (throw_force !== 10'd0 || charging !== 1'b0 || throw_enable !== 1'b0) begin
            errors++;
            $display("FAIL abort_charge got force=%0d chg=%b en=%b want 0/0/0",
                     throw_force, charging, throw_enable);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (throw_enable !== 1'b0 || throw_force !== 10'd0 || turn_over !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet got en=%b force=%0d over=%b want 0/0/0",
                         throw_enable, throw_force, turn_over);
            end
        end
    endtask

    task automatic test_launch();
        int c;
        int s1;
        int r;
        int hold;
        int exp_wind;
        exp_wind    = wind_of(m_lfsr);
        turn_active = 1'b1;
        btn         = 1'b1;
        step(6);
        c       = cyc;
        m_force = FMIN;
        m_up    = 1'b1;
        s1 = c + 1;
        while (!is_tick_edge(s1)) s1++;
        // The release is seen on a tick edge after exactly five applied ticks.
        r = s1 + 16 - 2;
        while (cyc < r + 5) begin
            step();
            if (is_tick_edge(cyc)) model_tick();
            checks++;
            if (throw_force !== 10'(m_force) || charging !== 1'b1) begin
                errors++;
                $display("FAIL launch_ramp cyc=%0d got force=%0d chg=%b want %0d/1",
                         cyc, throw_force, charging, m_force);
            end
            if (cyc == r) btn = 1'b0;
        end
        step();
        checks++;
        if (throw_enable !== 1'b1 || throw_force !== 10'd124 || charging !== 1'b0) begin
            errors++;
            $display("FAIL launch_latch got en=%b force=%0d chg=%b want 1/124/0",
                     throw_enable, throw_force, charging);
        end
        hold = $urandom_range(4, 12);
        for (int i = 0; i < hold; i++) begin
            if (i == hold / 2) turn_active = 1'b0;
            step();
            checks++;
            if (throw_enable !== 1'b1 || throw_force !== 10'd124 || wind_force !== 7'(exp_wind) ||
                turn_over !== 1'b0) begin
                errors++;
                $display("FAIL launch_hold got en=%b force=%0d wind=%0d over=%b want 1/124/%0d/0",
                         throw_enable, throw_force, wind_force, turn_over, exp_wind);
            end
        end
        throw_done = 1'b1;
        step();
        throw_done = 1'b0;
        checks++;
        if (throw_enable !== 1'b0 || turn_over !== 1'b1) begin
            errors++;
            $display("FAIL done_edge got en=%b over=%b want 0/1", throw_enable, turn_over);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (turn_over !== 1'b0 || throw_enable !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse got over=%b en=%b want 0/0", turn_over, throw_enable);
            end
        end
    endtask

    task automatic test_held_button();
        btn = 1'b1;
        step(8);
        turn_active = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (charging !== 1'b0 || throw_force !== 10'd0) begin
                errors++;
                $display("FAIL held_press got chg=%b force=%0d want 0/0", charging, throw_force);
            end
        end
        btn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (charging !== 1'b0) begin
                errors++;
                $display("FAIL held_release got chg=%b want 0", charging);
            end
        end
        btn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (charging !== 1'b0) begin
                errors++;
                $display("FAIL repress_latency got chg=%b want 0", charging);
            end
        end
        step();
        checks++;
        if (charging !== 1'b1 || throw_force !== 10'd64) begin
            errors++;
            $display("FAIL repress_charge got chg=%b force=%0d want 1/64", charging, throw_force);
        end
        turn_active = 1'b0;
        btn         = 1'b0;
        step(8);
    endtask

    task automatic test_wind_turns();
        int exp_wind;
        int len;
        for (int t = 0; t < 200; t++) begin
            step($urandom_range(1, 30));
            exp_wind    = wind_of(m_lfsr);
            turn_active = 1'b1;
            len = $urandom_range(2, 8);
            for (int i = 0; i < len; i++) begin
                step();
                checks++;
                if (wind_force !== 7'(exp_wind) || wind_force > 7'd100) begin
                    errors++;
                    $display("FAIL wind_turn turn=%0d got %0d want %0d (<=100)",
                             t, wind_force, exp_wind);
                end
            end
            turn_active = 1'b0;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_ramp_abort();
        test_launch();
        test_held_button();
        test_wind_turns();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
